decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32I decode stage; the producer side of the ALU interface. Takes fetched instructions over valid/ready
//  and emits one ALU-ready bundle per instruction to execute: alu_op, register addresses, immediate and control bits.
//  Holds a single pipeline register between fetch and execute; supports backpressure and flush.
// PARAMETERS
//  DATA_WIDTH  32  datapath/immediate width (only 32 supported)
//  ADDR_WIDTH  32  PC width
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  flush        in   1           discard held/incoming instruction
//  if_valid     in   1           fetch offers instruction
//  if_ready     out  1           decode accepts this cycle
//  if_instr     in   32          instruction word
//  if_pc        in   ADDR_WIDTH  PC of if_instr
//  ex_valid     out  1           bundle valid to execute
//  ex_ready     in   1           execute consumes bundle
//  ex_pc        out  ADDR_WIDTH  PC of held instruction
//  ex_alu_op    out  alu_ops_e   ALU operation
//  ex_rs1_addr  out  5           source reg 1
//  ex_rs2_addr  out  5           source reg 2
//  ex_rd_addr   out  5           destination reg
//  ex_imm       out  DATA_WIDTH  sign-extended immediate
//  ex_use_imm   out  1           ALU b operand = ex_imm
//  ex_is_branch out  1           result is a branch condition
//  ex_reg_write out  1           write rd with ALU result
//  ex_illegal   out  1           unsupported encoding
// BEHAVIOUR
//  - Reset: ex_valid=0, ex_alu_op=ALU_NOP, all other ex_* = 0. if_ready=1 out of reset.
//  - if_ready = !ex_valid || ex_ready (combinational). Capture on if_valid && if_ready; latency 1 cycle.
//  - ex_valid && !ex_ready: all ex_* held stable; no new capture.
//  - Consume without new capture: ex_valid -> 0 next cycle. Consume + capture same cycle: new bundle next cycle.
//  - flush: ex_valid -> 0 next cycle, overrides capture; if_ready unaffected.
//  - Decode (opcode -> ALU op):
//    OP 0110011: f3 000 ADD/SUB(f7=0100000), 001 SLL, 010 LT, 011 LTU, 100 XOR, 101 SRL/SRA(f7=0100000), 110 OR, 111 AND.
//      f7 not 0000000/0100000, or 0100000 with f3 not 000/101 -> illegal.
//    OP-IMM 0010011: same map; imm = sext(instr[31:20]), use_imm=1, never SUB.
//      Shifts: imm = instr[24:20] zero-ext; f7 check as OP.
//    BRANCH 1100011: 000 EQUALS, 001 NOT_EQUALS, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 illegal.
//      imm = sext B-type, is_branch=1, reg_write=0, use_imm=0.
//    LUI 0110111: ALU_ADD, rs1=0, imm={instr[31:12],12'b0}, use_imm=1.
//  - reg_write=1 for OP/OP-IMM/LUI only when rd!=0.
//  - Illegal/unknown opcode: ex_illegal=1, ALU_NOP, reg_write=0, is_branch=0, imm=0; still handshaked as a bundle.
//  - Reset mid-operation: held bundle dropped immediately (async); no partial state survives.
// STRUCTURE
//  - isa_shared adds: alu_ops_e members ALU_SLL/SRL/SRA/XOR/OR/AND; opcode constants OPC_OP, OPC_OP_IMM,
//    OPC_BRANCH, OPC_LUI; funct7 constants F7_BASE, F7_ALT; struct decoded_instr_t (all ex_* fields but valid).
//  - Sub-module instr_decoder: pure combinational instr -> decoded_instr_t. decode_stage adds the handshake register.
// TESTING
//  - rst_n=0 -> ex_valid=0, ex_alu_op=ALU_NOP, if_ready=1; release, if_valid=0 -> ex_valid stays 0.
//  - 0x40B50533 (sub x10,x10,x11), ex_ready=1 -> next cycle ALU_SUB, rs1=10, rs2=11, rd=10, use_imm=0, reg_write=1.
//  - 0xFFF00293 (addi x5,x0,-1) -> ALU_ADD, imm=0xFFFFFFFF, use_imm=1, rd=5, reg_write=1.
//  - 0xFE20CEE3 (blt x1,x2,-4) -> ALU_LT, imm=0xFFFFFFFC, is_branch=1, reg_write=0.
//  - ex_ready=0 for 3 cycles with bundle held -> if_ready=0, ex_* unchanged; ex_ready=1 -> next instr appears next cycle.
//  - 0xFFFFFFFF -> ex_illegal=1, ALU_NOP; then flush=1 with if_valid=1 -> ex_valid=0 the following cycle.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: ALU operation set, opcode/funct7 encodings,
// and the decoded bundle that travels from decode to execute.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_NOP        = 4'd0,
    ALU_ADD        = 4'd1,
    ALU_SUB        = 4'd2,
    ALU_SLL        = 4'd3,
    ALU_SRL        = 4'd4,
    ALU_SRA        = 4'd5,
    ALU_XOR        = 4'd6,
    ALU_OR         = 4'd7,
    ALU_AND        = 4'd8,
    ALU_LT         = 4'd9,
    ALU_LTU        = 4'd10,
    ALU_EQUALS     = 4'd11,
    ALU_NOT_EQUALS = 4'd12,
    ALU_GE         = 4'd13,
    ALU_GEU        = 4'd14
  } alu_ops_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Everything execute needs except the valid bit. The PC is carried beside
  // this struct because its width is a stage parameter.
  typedef struct packed {
    alu_ops_e    alu_op;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic        use_imm;
    logic        is_branch;
    logic        reg_write;
    logic        illegal;
  } decoded_instr_t;

  // Arithmetic funct3 map shared by OP and OP-IMM; alt selects SUB/SRA.
  function automatic alu_ops_e arith_op(input logic [2:0] f3, input logic alt);
    alu_ops_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_LT;
      3'b011:  op = ALU_LTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // funct7 is either the base encoding, or the alternate one on ADD/SUB and SRL/SRA.
  function automatic logic f7_legal(input logic [2:0] f3, input logic [6:0] f7);
    return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// master = the decode stage, slave = its fetch/execute environment.
interface decode_stage_if
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic                  if_valid;
  logic                  if_ready;
  logic [31:0]           if_instr;
  logic [ADDR_WIDTH-1:0] if_pc;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [ADDR_WIDTH-1:0] ex_pc;
  alu_ops_e              ex_alu_op;
  logic [4:0]            ex_rs1_addr;
  logic [4:0]            ex_rs2_addr;
  logic [4:0]            ex_rd_addr;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic                  ex_use_imm;
  logic                  ex_is_branch;
  logic                  ex_reg_write;
  logic                  ex_illegal;

  modport master (
    input  if_valid, if_instr, if_pc, ex_ready,
    output if_ready, ex_valid, ex_pc, ex_alu_op, ex_rs1_addr, ex_rs2_addr,
           ex_rd_addr, ex_imm, ex_use_imm, ex_is_branch, ex_reg_write, ex_illegal
  );

  modport slave (
    output if_valid, if_instr, if_pc, ex_ready,
    input  if_ready, ex_valid, ex_pc, ex_alu_op, ex_rs1_addr, ex_rs2_addr,
           ex_rd_addr, ex_imm, ex_use_imm, ex_is_branch, ex_reg_write, ex_illegal
  );

endinterface

// File: rtl/decode_stage_instr_decoder.sv
// Pure combinational RV32I subset decoder: instruction word -> decoded bundle.
module instr_decoder
  import decode_stage_pkg::*;
(
  input  logic [31:0]    instr,
  output decoded_instr_t dec
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] f3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] f7;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign f3       = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign f7       = instr[31:25];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Field extraction per format; any illegal encoding collapses to a clean NOP bundle.
  always_comb begin
    logic bad;
    bad        = 1'b0;
    dec        = '0;
    dec.alu_op = ALU_NOP;
    case (opcode)
      OPC_OP: begin
        dec.rs1_addr  = rs1;
        dec.rs2_addr  = rs2;
        dec.rd_addr   = rd;
        dec.reg_write = (rd != 5'd0);
        dec.alu_op    = arith_op(f3, f7 == F7_ALT);
        bad           = !f7_legal(f3, f7);
      end
      OPC_OP_IMM: begin
        dec.rs1_addr  = rs1;
        dec.rd_addr   = rd;
        dec.use_imm   = 1'b1;
        dec.reg_write = (rd != 5'd0);
        if (is_shift) begin
          // Shift amount is the low five immediate bits; the upper bits act as funct7.
          dec.imm    = {27'd0, instr[24:20]};
          dec.alu_op = arith_op(f3, f7 == F7_ALT);
          bad        = !f7_legal(f3, f7);
        end else begin
          // Immediate bit 30 is data here, so ADDI never becomes SUB.
          dec.imm    = {{20{instr[31]}}, instr[31:20]};
          dec.alu_op = arith_op(f3, 1'b0);
        end
      end
      OPC_BRANCH: begin
        dec.rs1_addr  = rs1;
        dec.rs2_addr  = rs2;
        dec.is_branch = 1'b1;
        dec.imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (f3)
          3'b000:  dec.alu_op = ALU_EQUALS;
          3'b001:  dec.alu_op = ALU_NOT_EQUALS;
          3'b100:  dec.alu_op = ALU_LT;
          3'b101:  dec.alu_op = ALU_GE;
          3'b110:  dec.alu_op = ALU_LTU;
          3'b111:  dec.alu_op = ALU_GEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.alu_op    = ALU_ADD;
        dec.rd_addr   = rd;
        dec.imm       = {instr[31:12], 12'd0};
        dec.use_imm   = 1'b1;
        dec.reg_write = (rd != 5'd0);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.alu_op  = ALU_NOP;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one pipeline register between fetch and execute
// with valid/ready backpressure and flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  decode_stage_if.master bus
);

  decoded_instr_t        dec;
  decoded_instr_t        bundle_q, bundle_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  if_ready;
  logic                  capture;

  instr_decoder u_decoder (
    .instr (bus.if_instr),
    .dec   (dec)
  );

  // Next-state of the holding register: flush wins, then capture, then drain.
  always_comb begin
    if_ready = !valid_q || bus.ex_ready;
    capture  = bus.if_valid && if_ready;
    valid_d  = valid_q;
    bundle_d = bundle_q;
    pc_d     = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d  = 1'b1;
      bundle_d = dec;
      pc_d     = bus.if_pc;
    end else if (bus.ex_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register; reset drops any held bundle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q         <= 1'b0;
      bundle_q        <= '0;
      bundle_q.alu_op <= ALU_NOP;
      pc_q            <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
    end
  end

  assign bus.if_ready     = if_ready;
  assign bus.ex_valid     = valid_q;
  assign bus.ex_pc        = pc_q;
  assign bus.ex_alu_op    = bundle_q.alu_op;
  assign bus.ex_rs1_addr  = bundle_q.rs1_addr;
  assign bus.ex_rs2_addr  = bundle_q.rs2_addr;
  assign bus.ex_rd_addr   = bundle_q.rd_addr;
  assign bus.ex_imm       = DATA_WIDTH'(bundle_q.imm);
  assign bus.ex_use_imm   = bundle_q.use_imm;
  assign bus.ex_is_branch = bundle_q.is_branch;
  assign bus.ex_reg_write = bundle_q.reg_write;
  assign bus.ex_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  int vectors    = 0;
  int miscompares = 0;

  decode_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  decode_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Lookup tables straight from the RV32I funct3 assignments.
  alu_ops_e arith_tab  [8] = '{ALU_ADD, ALU_SLL, ALU_LT, ALU_LTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  alu_ops_e branch_tab [8] = '{ALU_EQUALS, ALU_NOT_EQUALS, ALU_NOP, ALU_NOP, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the instruction-set rules.
  function automatic decoded_instr_t ref_decode(input logic [31:0] w);
    decoded_instr_t r;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        shift;
    logic        legal;
    logic [12:0] boff;
    opc   = w[6:0];
    f3    = w[14:12];
    f7    = w[31:25];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    legal = 1'b1;
    r     = '0;
    r.alu_op = ALU_NOP;
    if (opc == 7'h33 || opc == 7'h13) begin
      r.rs1_addr  = w[19:15];
      r.rd_addr   = w[11:7];
      r.reg_write = (w[11:7] != 5'd0);
      r.alu_op    = arith_tab[f3];
      if (opc == 7'h33 || shift) begin
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) legal = 1'b0;
        if (f7 == 7'h20 && f3 == 3'd0) r.alu_op = ALU_SUB;
        if (f7 == 7'h20 && f3 == 3'd5) r.alu_op = ALU_SRA;
      end
      if (opc == 7'h33) begin
        r.rs2_addr = w[24:20];
      end else begin
        r.use_imm = 1'b1;
        r.imm     = shift ? 32'(w[24:20]) : 32'($signed(w[31:20]));
      end
    end else if (opc == 7'h63) begin
      r.alu_op    = branch_tab[f3];
      legal       = (branch_tab[f3] != ALU_NOP);
      r.rs1_addr  = w[19:15];
      r.rs2_addr  = w[24:20];
      r.is_branch = 1'b1;
      boff        = {w[31], w[7], w[30:25], w[11:8], 1'b0};
      r.imm       = 32'($signed(boff));
    end else if (opc == 7'h37) begin
      r.alu_op    = ALU_ADD;
      r.rd_addr   = w[11:7];
      r.imm       = w & 32'hFFFF_F000;
      r.use_imm   = 1'b1;
      r.reg_write = (w[11:7] != 5'd0);
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      r         = '0;
      r.alu_op  = ALU_NOP;
      r.illegal = 1'b1;
    end
    return r;
  endfunction

  // Transaction-level model: what execute should be holding after each edge.
  logic           m_valid;
  decoded_instr_t m_b;
  logic [31:0]    m_pc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (bus.if_valid && (!m_valid || bus.ex_ready)) begin
      m_valid <= 1'b1;
      m_b     <= ref_decode(bus.if_instr);
      m_pc    <= bus.if_pc;
    end else if (bus.ex_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    check("if_ready", 32'(bus.if_ready), 32'(!m_valid || bus.ex_ready));
    if (m_valid) begin
      check("ex_pc",        bus.ex_pc,                m_pc);
      check("ex_alu_op",    32'(bus.ex_alu_op),       32'(m_b.alu_op));
      check("ex_rs1_addr",  32'(bus.ex_rs1_addr),     32'(m_b.rs1_addr));
      check("ex_rs2_addr",  32'(bus.ex_rs2_addr),     32'(m_b.rs2_addr));
      check("ex_rd_addr",   32'(bus.ex_rd_addr),      32'(m_b.rd_addr));
      check("ex_imm",       bus.ex_imm,               m_b.imm);
      check("ex_use_imm",   32'(bus.ex_use_imm),      32'(m_b.use_imm));
      check("ex_is_branch", 32'(bus.ex_is_branch),    32'(m_b.is_branch));
      check("ex_reg_write", 32'(bus.ex_reg_write),    32'(m_b.reg_write));
      check("ex_illegal",   32'(bus.ex_illegal),      32'(m_b.illegal));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  // Random instruction biased towards the supported opcodes and funct7 values.
  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    int          f;
    w = $urandom();
    k = $urandom_range(0, 9);
    f = $urandom_range(0, 3);
    if (k <= 2)      w[6:0] = 7'h33;
    else if (k <= 5) w[6:0] = 7'h13;
    else if (k <= 7) w[6:0] = 7'h63;
    else if (k == 8) w[6:0] = 7'h37;
    if (k <= 5) begin
      if (f <= 1)      w[31:25] = 7'h00;
      else if (f == 2) w[31:25] = 7'h20;
    end
    return w;
  endfunction

  initial begin
    logic in_rst;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.ex_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);

    // Reset state
    @(negedge clk);
    check("rst_ex_valid",  32'(bus.ex_valid),  32'd0);
    check("rst_alu_op",    32'(bus.ex_alu_op), 32'(ALU_NOP));
    check("rst_if_ready",  32'(bus.if_ready),  32'd1);
    check("rst_ex_imm",    bus.ex_imm,         32'd0);
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("idle_ex_valid", 32'(bus.ex_valid), 32'd0);

    // sub x10,x10,x11 -> addi x5,x0,-1 -> blt x1,x2,-4
    step();
    drive(1'b1, 32'h40B5_0533, 32'h100);
    step();
    drive(1'b1, 32'hFFF0_0293, 32'h104);
    @(negedge clk);
    check("sub_op",  32'(bus.ex_alu_op),   32'(ALU_SUB));
    check("sub_rs1", 32'(bus.ex_rs1_addr), 32'd10);
    check("sub_rs2", 32'(bus.ex_rs2_addr), 32'd11);
    check("sub_rd",  32'(bus.ex_rd_addr),  32'd10);
    check("sub_ui",  32'(bus.ex_use_imm),  32'd0);
    check("sub_rw",  32'(bus.ex_reg_write), 32'd1);
    step();
    drive(1'b1, 32'hFE20_CEE3, 32'h108);
    @(negedge clk);
    check("addi_op",  32'(bus.ex_alu_op),    32'(ALU_ADD));
    check("addi_imm", bus.ex_imm,            32'hFFFF_FFFF);
    check("addi_ui",  32'(bus.ex_use_imm),   32'd1);
    check("addi_rd",  32'(bus.ex_rd_addr),   32'd5);
    check("addi_rw",  32'(bus.ex_reg_write), 32'd1);
    step();
    bus.ex_ready = 1'b0;
    drive(1'b1, 32'h00B5_0533, 32'h10C);
    @(negedge clk);
    check("blt_op",    32'(bus.ex_alu_op),    32'(ALU_LT));
    check("blt_imm",   bus.ex_imm,            32'hFFFF_FFFC);
    check("blt_br",    32'(bus.ex_is_branch), 32'd1);
    check("blt_rw",    32'(bus.ex_reg_write), 32'd0);
    check("blt_ready", 32'(bus.if_ready),     32'd0);

    // Backpressure: bundle held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("hold_ready", 32'(bus.if_ready),  32'd0);
      check("hold_op",    32'(bus.ex_alu_op), 32'(ALU_LT));
      check("hold_pc",    bus.ex_pc,          32'h108);
    end
    step();
    bus.ex_ready = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(bus.if_ready), 32'd1);
    step();
    drive(1'b1, 32'hFFFF_FFFF, 32'h110);
    @(negedge clk);
    check("next_op", 32'(bus.ex_alu_op), 32'(ALU_ADD));
    check("next_pc", bus.ex_pc,          32'h10C);

    // Illegal word, then flush overriding a capture
    step();
    flush = 1'b1;
    drive(1'b1, 32'h00B5_0533, 32'h114);
    @(negedge clk);
    check("ill_flag",  32'(bus.ex_illegal), 32'd1);
    check("ill_op",    32'(bus.ex_alu_op),  32'(ALU_NOP));
    check("ill_valid", 32'(bus.ex_valid),   32'd1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("flush_valid", 32'(bus.ex_valid), 32'd0);

    // Randomized traffic with occasional flush and asynchronous reset
    in_rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (in_rst) begin
        rst_n  = 1'b1;
        in_rst = 1'b0;
      end
      flush        = ($urandom_range(0, 19) == 0);
      bus.ex_ready = ($urandom_range(0, 9) < 7);
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom());
      if ($urandom_range(0, 149) == 0) begin
        rst_n  = 1'b0;
        in_rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.ex_valid), 32'd0);
      end
    end
    step();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
